mux_scan_nx1: RTL and testbench
===============================

# mux_scan_nx1

Registered N-input, W-bit multiplexer with two modes: manual select (s chooses the channel) and auto-scan (an internal pointer cycles through all channels, holding each for DWELL enabled cycles). It generalises the team's combinational 4:1 single-bit mux to parametrised width and channel count. It adds a registered output, valid/selected-channel tagging and a scan wrap pulse. It sits between a bank of sampled sources and a single downstream consumer, such as a display or serial logger, that services one channel at a time.

## Interface
- W, default 8: data width per channel, ≥1.
- N, default 4: number of input channels, 2 ≤ N ≤ 2^SW.
- SW, default 2: select/pointer width.
- DWELL, default 4: enabled cycles spent on each channel in scan mode, ≥1.

- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- i  input  N*W  flattened channel data; channel k = i[k*W +: W].
- s  input  SW  manual channel select, sampled only in manual mode.
- mode  input  1  0 = manual, 1 = auto-scan.
- en  input  1  advance/sample enable.
- o  output  W  registered selected data.
- o_sel  output  SW  channel index that produced o.
- o_valid  output  1  o/o_sel updated this cycle with a legal channel.
- wrap  output  1  one-cycle pulse: scan pointer moved from N-1 to 0.

## Operation
- The internal state register st has two values, MAN and SCAN. It is updated only on cycles with en=1: st <= mode ? SCAN : MAN.
- The pointer ch (SW bits) and dwell counter dc (width $clog2(DWELL) bits, minimum 1) are also internal.
- On a cycle with en=0:
  - o, o_sel, st, ch and dc hold.
  - o_valid=0 and wrap=0 on the next edge.
- On a cycle with en=1 and mode=0 (manual):
  - If s < N: o <= channel s, o_sel <= s, o_valid <= 1.
  - If s ≥ N: o <= 0, o_sel <= s, o_valid <= 0.
  - ch and dc hold. wrap <= 0.
- On a cycle with en=1 and mode=1 (scan), first compute the effective values:
  - cur = (st==SCAN) ? ch : 0.
  - dcur = (st==SCAN) ? dc : 0.
  - Entering scan from MAN therefore always restarts at channel 0 with a fresh dwell.
- The scan cycle then updates registers as follows:
  - o <= channel cur, o_sel <= cur, o_valid <= 1.
  - If dcur == DWELL-1: dc <= 0 and ch <= (cur==N-1) ? 0 : cur+1. wrap <= (cur==N-1).
  - Otherwise: dc <= dcur+1, ch <= cur, wrap <= 0.
- Leaving scan for manual preserves ch/dc. They are ignored on re-entry because re-entry restarts at 0.
- Wrap-around is exact at N. The pointer never takes values ≥ N, even when N < 2^SW.
- Reset (rst=1 at an edge) overrides en and mode:
  - o=0, o_sel=0, o_valid=0, wrap=0.
  - st=MAN, ch=0, dc=0.
  - Reset asserted mid-dwell abandons the scan. The first scan cycle after reset outputs channel 0.

## Timing
- Latency is 1 cycle: inputs sampled at edge t appear on o/o_sel/o_valid after edge t.
- No combinational path from any input to any output.
- In scan mode with en held high, each channel is presented for exactly DWELL consecutive cycles. The full sequence is 0,0..,1,1..,N-1, with period N*DWELL cycles.
- wrap asserts on the same output cycle that o_sel first shows 0 again? No: wrap is asserted together with the last output of channel N-1, i.e. the cycle on which o_sel=N-1 and the dwell completes. It lasts exactly one cycle.
- Gaps in en stretch the dwell. Only enabled cycles count toward DWELL.
- When mode toggles, the new mode takes effect on the same enabled cycle in which it is seen.

## Test plan
- Manual, W=8, N=4: i={ch3=8'hA5, ch2=8'h3C, ch1=8'h01, ch0=8'h00}, s=2'b10, en=1 → one cycle later o=8'h3C, o_sel=2, o_valid=1. Change ch2 to 8'h77 → o=8'h77 next cycle.
- Out-of-range select, N=3, SW=2: s=3, en=1 → o=0, o_sel=3, o_valid=0.
- Scan, N=3, DWELL=2, en=1 continuously from reset → o_sel sequence 0,0,1,1,2,2,0,0…
  - wrap=1 only on the second cycle of o_sel=2, repeating every 6 cycles.
- Enable gaps in scan: en pattern 1,0,1 during channel 0 with DWELL=2.
  - o_valid pattern 1,0,1, and o_sel stays 0 across the gap.
  - Channel 1 appears on the next enabled cycle.
- Mode switch and reset: scan to ch=2 mid-dwell, then mode=0 with s=1 → o_sel=1. Then mode=1 → o_sel restarts at 0.
  - Separately, assert rst for 1 cycle mid-scan → all outputs 0 next cycle, and the next scan output is o_sel=0.

Source files
------------

// File: rtl/mux_scan_nx1.sv
// Registered N-input, W-bit multiplexer with manual select and auto-scan modes.
// Scan holds each channel for DWELL enabled cycles and pulses wrap on the last cycle of channel N-1.
module mux_scan_nx1 #(
  parameter int W     = 8,
  parameter int N     = 4,
  parameter int SW    = 2,
  parameter int DWELL = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] i,
  input  logic [SW-1:0]  s,
  input  logic           mode,
  input  logic           en,
  output logic [W-1:0]   o,
  output logic [SW-1:0]  o_sel,
  output logic           o_valid,
  output logic           wrap
);

  localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [0:0] MAN  = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  logic [0:0]     st;
  logic [SW-1:0]  ch;
  logic [DCW-1:0] dc;

  logic [SW-1:0]  cur;
  logic [DCW-1:0] dcur;
  logic [SW-1:0]  sel;
  logic [W-1:0]   sel_data;
  logic           sel_ok;
  logic           dwell_done;
  logic           last_ch;

  // Entering scan from manual always restarts at channel 0 with a fresh dwell.
  always_comb begin
    cur      = (st == SCAN) ? ch : '0;
    dcur     = (st == SCAN) ? dc : '0;
    sel      = mode ? cur : s;
    sel_data = '0;
    sel_ok   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (sel == SW'(k)) begin
        sel_data = i[k*W +: W];
        sel_ok   = 1'b1;
      end
    end
    dwell_done = (dcur == DCW'(DWELL - 1));
    last_ch    = (cur == SW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o       <= '0;
      o_sel   <= '0;
      o_valid <= 1'b0;
      wrap    <= 1'b0;
      st      <= MAN;
      ch      <= '0;
      dc      <= '0;
    end else begin
      o_valid <= 1'b0;
      wrap    <= 1'b0;
      if (en) begin
        st      <= mode ? SCAN : MAN;
        o_sel   <= sel;
        o       <= sel_ok ? sel_data : '0;
        o_valid <= sel_ok;
        if (mode) begin
          if (dwell_done) begin
            dc   <= '0;
            ch   <= last_ch ? '0 : cur + SW'(1);
            wrap <= last_ch;
          end else begin
            dc <= dcur + DCW'(1);
            ch <= cur;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Directed bench for mux_scan_nx1 with N=3, SW=2, DWELL=2, W=8.
module tb_mux_scan_nx1;

  localparam int W = 8, N = 3, SW = 2, DWELL = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   ch_data [N];
  logic [N*W-1:0] i;
  logic [SW-1:0]  s;
  logic           mode;
  logic           en;
  logic [W-1:0]   o;
  logic [SW-1:0]  o_sel;
  logic           o_valid;
  logic           wrap;

  int tests_run = 0;
  int tests_failed = 0;

  assign i = {ch_data[2], ch_data[1], ch_data[0]};

  mux_scan_nx1 #(.W(W), .N(N), .SW(SW), .DWELL(DWELL)) dut (
    .clk(clk), .rst(rst), .i(i), .s(s), .mode(mode), .en(en),
    .o(o), .o_sel(o_sel), .o_valid(o_valid), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] e_o, input logic [SW-1:0] e_sel,
                           input logic e_valid, input logic e_wrap);
    check({tag, ".o"},       32'(o),       32'(e_o));
    check({tag, ".o_sel"},   32'(o_sel),   32'(e_sel));
    check({tag, ".o_valid"}, 32'(o_valid), 32'(e_valid));
    check({tag, ".wrap"},    32'(wrap),    32'(e_wrap));
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; mode = 1'b1; s = '0;
    ch_data[0] = 8'h5A; ch_data[1] = 8'h01; ch_data[2] = 8'h3C;
    step(); step();
    check_out("reset", 8'h00, 2'd0, 1'b0, 1'b0);

    // Manual select
    rst = 1'b0; mode = 1'b0; s = 2'd2;
    step();
    check_out("man_s2", 8'h3C, 2'd2, 1'b1, 1'b0);
    ch_data[2] = 8'h77;
    step();
    check_out("man_s2_upd", 8'h77, 2'd2, 1'b1, 1'b0);
    s = 2'd3;
    step();
    check_out("man_oor", 8'h00, 2'd3, 1'b0, 1'b0);
    s = 2'd0;
    step();
    check_out("man_s0", 8'h5A, 2'd0, 1'b1, 1'b0);
    en = 1'b0; s = 2'd1;
    step();
    check_out("man_hold", 8'h5A, 2'd0, 1'b0, 1'b0);

    // Continuous scan: 0,0,1,1,2,2 with wrap on the second cycle of channel 2
    en = 1'b1; mode = 1'b1;
    for (int k = 0; k < 12; k++) begin
      int c;
      c = (k / 2) % 3;
      step();
      check_out($sformatf("scan%0d", k), ch_data[c], SW'(c), 1'b1, (k % 6) == 5);
    end

    // Enable gap during channel 0
    step();
    check_out("gap_a", 8'h5A, 2'd0, 1'b1, 1'b0);
    en = 1'b0;
    step();
    check_out("gap_b", 8'h5A, 2'd0, 1'b0, 1'b0);
    en = 1'b1;
    step();
    check_out("gap_c", 8'h5A, 2'd0, 1'b1, 1'b0);
    step();
    check_out("gap_d", 8'h01, 2'd1, 1'b1, 1'b0);
    step();
    check_out("gap_e", 8'h01, 2'd1, 1'b1, 1'b0);
    step();
    check_out("mid_ch2", 8'h77, 2'd2, 1'b1, 1'b0);

    // Switch to manual mid-dwell, then back to scan restarts at channel 0
    mode = 1'b0; s = 2'd1;
    step();
    check_out("sw_man", 8'h01, 2'd1, 1'b1, 1'b0);
    mode = 1'b1;
    step();
    check_out("sw_scan_a", 8'h5A, 2'd0, 1'b1, 1'b0);
    step();
    check_out("sw_scan_b", 8'h5A, 2'd0, 1'b1, 1'b0);
    step();
    check_out("sw_scan_c", 8'h01, 2'd1, 1'b1, 1'b0);

    // Reset mid-dwell abandons the scan
    rst = 1'b1;
    step();
    check_out("rst_mid", 8'h00, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    check_out("post_rst_a", 8'h5A, 2'd0, 1'b1, 1'b0);
    step();
    check_out("post_rst_b", 8'h5A, 2'd0, 1'b1, 1'b0);
    step();
    check_out("post_rst_c", 8'h01, 2'd1, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
